mips_cycle_sequencer: RTL and testbench
=======================================

// Module: mips_cycle_sequencer
// PURPOSE
//  Multi-cycle FSM that steps the MIPS datapath through IF/ID/EX/MEM/WB per instruction.
//  Sits between ControlUnit datapath (regfile, alu, memory, branch/jump logic) and its strobes.
//  Selects stage path from opcode, waits on ALU/memory handshakes, issues PC update.
//  Stops on syscall, wait timeout, or (optionally) illegal opcode.
// PARAMETERS
//  WAIT_LIMIT  16  max cycles spent waiting in FETCH/EXECUTE/MEMORY before timeout
//  CNT_W       32  width of retired-instruction counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      leave IDLE/HALT and begin fetching
//  opcode       in   6      instr[31:26], valid during DECODE
//  funct        in   6      instr[5:0], valid during DECODE
//  alu_done     in   1      ALU result valid (EXECUTE handshake)
//  alu_zero     in   1      ALU zero flag, valid with alu_done
//  mem_ready    in   1      memory access complete (FETCH/MEMORY handshake)
//  if_en        out  1      high whole FETCH state (drives IF)
//  id_en        out  1      high whole DECODE state (drives ID)
//  ex_en        out  1      high whole EXECUTE state (drives EX)
//  mem_en       out  1      high whole MEMORY state (drives MEM)
//  mem_wen      out  1      high in MEMORY for sw only
//  wb_en        out  1      one-cycle pulse in WRITEBACK (drives WB)
//  pc_we        out  1      one-cycle pulse on the last cycle of each instruction
//  pc_src       out  2      valid with pc_we: 0 pc+4, 1 branch target, 2 jump target
//  busy         out  1      state not IDLE/HALT
//  halted       out  1      state is HALT
//  timeout_err  out  1      sticky; set when a wait exceeds WAIT_LIMIT
//  illegal_err  out  1      sticky; set on illegal-opcode trap
//  retired      out  CNT_W  instructions completed, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; every output 0; retired=0; wait counter 0.
//  - States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT. Outputs decoded from state reg.
//  - IDLE/HALT --start--> FETCH next edge; HALT->FETCH clears both error flags.
//  - FETCH: hold until mem_ready=1, then DECODE. DECODE: always 1 cycle, latches opcode class.
//  - Paths after DECODE:
//      R-type 0x00:        EX -> WB   (funct 0x0C syscall: DECODE -> HALT, no pc_we)
//      I-ALU 0x08..0x0F:   EX -> WB
//      lw 0x23:            EX -> MEM -> WB
//      sw 0x2B:            EX -> MEM (mem_wen=1), no WB
//      beq 0x04/bne 0x05:  EX only; pc_src=1 if alu_zero==1 (beq) / ==0 (bne), else 0
//      j 0x02:             done in DECODE, pc_src=2;  jal 0x03: DECODE -> WB, pc_src=2
//      other:              treated as NOP, done in DECODE with pc_src=0
//  - EXECUTE holds until alu_done=1; MEMORY holds until mem_ready=1; WRITEBACK is 1 cycle.
//  - Completion: in final state's exit cycle pc_we=1, retired+=1, next state FETCH.
//  - Wait counter resets on state entry, increments each stalled cycle; when it reaches
//    WAIT_LIMIT with handshake still 0: timeout_err=1, -> HALT, no pc_we.
//  - Handshake seen in same cycle the counter hits WAIT_LIMIT: handshake wins, no timeout.
//  - start ignored while busy. Handshake inputs ignored outside their waiting states.
//  - rst_n asserted mid-instruction: immediate return to IDLE, partial instruction discarded.
// CONFIGURATION
//  SEQ_ILLEGAL_TRAP_EN defined: unlisted opcode -> DECODE -> HALT, illegal_err=1, no pc_we,
//    retired unchanged.
//  Not defined: unlisted opcode retires as NOP (pc_we, pc_src=0); illegal_err tied 0.
// TESTING
//  - rst_n=0 mid-EXECUTE -> all outputs 0, state IDLE, retired=0 same cycle.
//  - start; op 0x00 funct 0x20, mem_ready@FETCH c1, alu_done after 2 stalls -> IF1,ID1,EX3,WB1;
//    pc_we with pc_src=0; retired=1.
//  - lw 0x23 then sw 0x2B, mem_ready 1 cycle late -> lw visits MEM+WB; sw mem_wen=1, no wb_en.
//  - beq 0x04 alu_zero=1 -> pc_src=1; bne 0x05 alu_zero=1 -> pc_src=0; j 0x02 -> pc_src=2
//    after DECODE, no ex_en; jal 0x03 -> wb_en pulse, pc_src=2.
//  - WAIT_LIMIT=4, alu_done held 0 -> HALT after 4 EX cycles, timeout_err=1, pc_we never 1;
//    start -> FETCH, timeout_err cleared.
//  - op 0x3F: with SEQ_ILLEGAL_TRAP_EN -> HALT, illegal_err=1; without -> pc_we, retired+1.

Source files
------------

// File: rtl/mips_cycle_sequencer.sv
// mips_cycle_sequencer
//   Multi-cycle control FSM that walks one MIPS instruction at a time through
//   IF / ID / EX / MEM / WB. The path is chosen from the opcode in DECODE. The FSM
//   waits on the ALU and memory handshakes and issues the PC update on the
//   last cycle of every instruction. It stops on syscall or on a handshake
//   timeout. It can also stop on an illegal opcode.
//
//   Build option: define SEQ_ILLEGAL_TRAP_EN to trap unlisted opcodes into HALT
//   with illegal_err_o set. Without it they retire as a NOP and illegal_err_o
//   is tied to 0.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start_i             leave IDLE/HALT and begin fetching (ignored while busy)
//   opcode_i, funct_i   instr[31:26] / instr[5:0], sampled in DECODE
//   alu_done_i          ALU result valid, EXECUTE handshake
//   alu_zero_i          ALU zero flag, qualified by alu_done_i
//   mem_ready_i         memory access complete, FETCH/MEMORY handshake
//   if_en_o .. wb_en_o  stage enables, registered state decode
//   mem_wen_o           store strobe, high in MEMORY for sw
//   pc_we_o, pc_src_o   PC update on the exit cycle of an instruction
//                       pc_src_o: 0 pc+4, 1 branch target, 2 jump target
//   busy_o, halted_o    state is not IDLE/HALT; state is HALT
//   timeout_err_o       sticky, a handshake wait exceeded WAIT_LIMIT
//   illegal_err_o       sticky, illegal-opcode trap
//   retired_o           count of completed instructions (wraps)

module mips_cycle_sequencer #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    input  logic             alu_done_i,
    input  logic             alu_zero_i,
    input  logic             mem_ready_i,
    output logic             if_en_o,
    output logic             id_en_o,
    output logic             ex_en_o,
    output logic             mem_en_o,
    output logic             mem_wen_o,
    output logic             wb_en_o,
    output logic             pc_we_o,
    output logic [1:0]       pc_src_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic             timeout_err_o,
    output logic             illegal_err_o,
    output logic [CNT_W-1:0] retired_o
);

    localparam int unsigned WaitW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StMemory,
        StWriteback,
        StHalt
    } state_e;

    // Instruction class latched in DECODE to steer the later stages.
    typedef enum logic [2:0] {
        ClsAlu,
        ClsLoad,
        ClsStore,
        ClsBeq,
        ClsBne,
        ClsJal
    } cls_e;

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q;
    logic               timeout_q;
    logic               if_en_q, id_en_q, ex_en_q, mem_en_q, mem_wen_q, wb_en_q;
    logic               busy_q, halted_q;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               set_timeout, clr_err;
    logic               wait_at_limit;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic               illegal_q;
    logic               set_illegal;
`endif

    // The last stalled cycle a wait may take. A handshake arriving in this
    // cycle still wins over the timeout.
    assign wait_at_limit = (wait_q == WaitW'(WAIT_LIMIT - 1));

    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        wait_d      = '0;
        pc_we       = 1'b0;
        pc_src      = 2'd0;
        set_timeout = 1'b0;
        clr_err     = 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
        set_illegal = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StFetch;
            end
            StHalt: begin
                if (start_i) begin
                    state_d = StFetch;
                    clr_err = 1'b1;
                end
            end
            StFetch: begin
                if (mem_ready_i) begin
                    state_d = StDecode;
                end else if (wait_at_limit) begin
                    state_d     = StHalt;
                    set_timeout = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StDecode: begin
                case (opcode_i) inside
                    6'h00: begin
                        if (funct_i == 6'h0C) begin
                            state_d = StHalt;  // syscall: stop without a PC update
                        end else begin
                            cls_d   = ClsAlu;
                            state_d = StExecute;
                        end
                    end
                    [6'h08:6'h0F]: begin
                        cls_d   = ClsAlu;
                        state_d = StExecute;
                    end
                    6'h23: begin
                        cls_d   = ClsLoad;
                        state_d = StExecute;
                    end
                    6'h2B: begin
                        cls_d   = ClsStore;
                        state_d = StExecute;
                    end
                    6'h04: begin
                        cls_d   = ClsBeq;
                        state_d = StExecute;
                    end
                    6'h05: begin
                        cls_d   = ClsBne;
                        state_d = StExecute;
                    end
                    6'h02: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'd2;
                        state_d = StFetch;
                    end
                    6'h03: begin
                        cls_d   = ClsJal;
                        state_d = StWriteback;
                    end
                    default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                        state_d     = StHalt;
                        set_illegal = 1'b1;
`else
                        pc_we   = 1'b1;
                        state_d = StFetch;
`endif
                    end
                endcase
            end
            StExecute: begin
                if (alu_done_i) begin
                    case (cls_q)
                        ClsLoad, ClsStore: state_d = StMemory;
                        ClsBeq: begin
                            pc_we   = 1'b1;
                            pc_src  = alu_zero_i ? 2'd1 : 2'd0;
                            state_d = StFetch;
                        end
                        ClsBne: begin
                            pc_we   = 1'b1;
                            pc_src  = alu_zero_i ? 2'd0 : 2'd1;
                            state_d = StFetch;
                        end
                        default: state_d = StWriteback;
                    endcase
                end else if (wait_at_limit) begin
                    state_d     = StHalt;
                    set_timeout = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StMemory: begin
                if (mem_ready_i) begin
                    if (cls_q == ClsStore) begin
                        pc_we   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (wait_at_limit) begin
                    state_d     = StHalt;
                    set_timeout = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StWriteback: begin
                pc_we   = 1'b1;
                pc_src  = (cls_q == ClsJal) ? 2'd2 : 2'd0;
                state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage enables are registered copies of the next-state decode, so they
    // track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cls_q     <= ClsAlu;
            wait_q    <= '0;
            retired_q <= '0;
            timeout_q <= 1'b0;
            if_en_q   <= 1'b0;
            id_en_q   <= 1'b0;
            ex_en_q   <= 1'b0;
            mem_en_q  <= 1'b0;
            mem_wen_q <= 1'b0;
            wb_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            if_en_q   <= (state_d == StFetch);
            id_en_q   <= (state_d == StDecode);
            ex_en_q   <= (state_d == StExecute);
            mem_en_q  <= (state_d == StMemory);
            mem_wen_q <= (state_d == StMemory) && (cls_d == ClsStore);
            wb_en_q   <= (state_d == StWriteback);
            busy_q    <= (state_d != StIdle) && (state_d != StHalt);
            halted_q  <= (state_d == StHalt);
            if (pc_we) retired_q <= retired_q + CNT_W'(1);
            if (clr_err) begin
                timeout_q <= 1'b0;
            end else if (set_timeout) begin
                timeout_q <= 1'b1;
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            if (clr_err) begin
                illegal_q <= 1'b0;
            end else if (set_illegal) begin
                illegal_q <= 1'b1;
            end
`endif
        end
    end

    assign if_en_o       = if_en_q;
    assign id_en_o       = id_en_q;
    assign ex_en_o       = ex_en_q;
    assign mem_en_o      = mem_en_q;
    assign mem_wen_o     = mem_wen_q;
    assign wb_en_o       = wb_en_q;
    assign pc_we_o       = pc_we;
    assign pc_src_o      = pc_src;
    assign busy_o        = busy_q;
    assign halted_o      = halted_q;
    assign timeout_err_o = timeout_q;
    assign retired_o     = retired_q;
`ifdef SEQ_ILLEGAL_TRAP_EN
    assign illegal_err_o = illegal_q;
`else
    assign illegal_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
module tb_mips_cycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_done;
    logic        alu_zero;
    logic        mem_ready;
    logic        if_en, id_en, ex_en, mem_en, mem_wen, wb_en, pc_we;
    logic [1:0]  pc_src;
    logic        busy, halted, timeout_err, illegal_err;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    // Observed vector: {if,id,ex,mem,wen,wb,pc_we,pc_src[1:0],busy,halt,terr,ierr}
    localparam logic [12:0] B_IF   = 13'h1000;
    localparam logic [12:0] B_ID   = 13'h0800;
    localparam logic [12:0] B_EX   = 13'h0400;
    localparam logic [12:0] B_MEM  = 13'h0200;
    localparam logic [12:0] B_WEN  = 13'h0100;
    localparam logic [12:0] B_WB   = 13'h0080;
    localparam logic [12:0] B_PCWE = 13'h0040;
    localparam logic [12:0] B_SRC1 = 13'h0010;
    localparam logic [12:0] B_SRC2 = 13'h0020;
    localparam logic [12:0] B_BUSY = 13'h0008;
    localparam logic [12:0] B_HALT = 13'h0004;
    localparam logic [12:0] B_TERR = 13'h0002;
    localparam logic [12:0] B_IERR = 13'h0001;

    localparam logic [12:0] E_IDLE = 13'h0000;
    localparam logic [12:0] S_IF   = B_IF | B_BUSY;
    localparam logic [12:0] S_ID   = B_ID | B_BUSY;
    localparam logic [12:0] S_EX   = B_EX | B_BUSY;
    localparam logic [12:0] S_MEM  = B_MEM | B_BUSY;
    localparam logic [12:0] S_WB   = B_WB | B_BUSY;
    localparam logic [12:0] S_HALT = B_HALT;

`ifdef SEQ_ILLEGAL_TRAP_EN
    localparam logic [31:0] RET_AFTER_ILL = 32'd8;
`else
    localparam logic [31:0] RET_AFTER_ILL = 32'd9;
`endif

    typedef struct packed {
        logic        st;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [2:0]  hs;   // {alu_done, alu_zero, mem_ready}
        logic [12:0] exp;
    } vec_t;

    mips_cycle_sequencer #(
        .WAIT_LIMIT(4),
        .CNT_W     (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .alu_done_i   (alu_done),
        .alu_zero_i   (alu_zero),
        .mem_ready_i  (mem_ready),
        .if_en_o      (if_en),
        .id_en_o      (id_en),
        .ex_en_o      (ex_en),
        .mem_en_o     (mem_en),
        .mem_wen_o    (mem_wen),
        .wb_en_o      (wb_en),
        .pc_we_o      (pc_we),
        .pc_src_o     (pc_src),
        .busy_o       (busy),
        .halted_o     (halted),
        .timeout_err_o(timeout_err),
        .illegal_err_o(illegal_err),
        .retired_o    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {if_en, id_en, ex_en, mem_en, mem_wen, wb_en, pc_we, pc_src,
                busy, halted, timeout_err, illegal_err};
    endfunction

    function automatic vec_t mk(logic st, logic [5:0] op, logic [5:0] fn, logic [2:0] hs,
                                logic [12:0] e);
        vec_t v;
        v.st = st; v.op = op; v.fn = fn; v.hs = hs; v.exp = e;
        return v;
    endfunction

    // Drive one cycle of inputs at the falling edge, settle, leave sampling to caller.
    task automatic apply(input vec_t v);
        @(negedge clk);
        start = v.st; opcode = v.op; funct = v.fn;
        {alu_done, alu_zero, mem_ready} = v.hs;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; opcode = '0; funct = '0;
        alu_done = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs() !== E_IDLE) begin
            $display("FAIL reset_outputs got %b want %b", obs(), E_IDLE); failures++;
        end
        checks++;
        if (retired !== 32'd0) begin
            $display("FAIL reset_retired got %0d want 0", retired); failures++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        vec_t v[$];
        v.push_back(mk(1'b1, 6'h00, 6'h00, 3'b000, E_IDLE));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h00, 6'h20, 3'b000, S_ID));
        v.push_back(mk(1'b1, 6'h00, 6'h00, 3'b001, S_EX));   // start/mem_ready ignored
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b100, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_WB | B_PCWE));
        foreach (v[i]) begin
            apply(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                $display("FAIL rtype cyc%0d got %b want %b", i, obs(), v[i].exp); failures++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== 32'd1) begin
            $display("FAIL rtype_retired got %0d want 1", retired); failures++;
        end
    endtask

    task automatic test_load_store();
        vec_t v[$];
        // lw: fetch one cycle late, memory one cycle late, then WB
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_IF));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h23, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b100, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_MEM));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_MEM));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_WB | B_PCWE));
        // sw: retires from MEMORY with mem_wen, no WB
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_IF));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h2B, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b100, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_MEM | B_WEN));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_MEM | B_WEN | B_PCWE));
        foreach (v[i]) begin
            apply(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                $display("FAIL load_store cyc%0d got %b want %b", i, obs(), v[i].exp);
                failures++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== 32'd3) begin
            $display("FAIL load_store_retired got %0d want 3", retired); failures++;
        end
    endtask

    task automatic test_branch_jump();
        vec_t v[$];
        // beq taken (alu_zero ignored until alu_done)
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h04, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b010, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b110, S_EX | B_PCWE | B_SRC1));
        // bne with zero: not taken
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h05, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b110, S_EX | B_PCWE));
        // bne without zero: taken
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h05, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b100, S_EX | B_PCWE | B_SRC1));
        // j: retires in DECODE
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h02, 6'h00, 3'b000, S_ID | B_PCWE | B_SRC2));
        // jal: DECODE -> WB
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h03, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_WB | B_PCWE | B_SRC2));
        foreach (v[i]) begin
            apply(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                $display("FAIL branch_jump cyc%0d got %b want %b", i, obs(), v[i].exp);
                failures++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== 32'd8) begin
            $display("FAIL branch_jump_retired got %0d want 8", retired); failures++;
        end
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
`ifdef SEQ_ILLEGAL_TRAP_EN
        v.push_back(mk(1'b0, 6'h3F, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_HALT | B_IERR));
        v.push_back(mk(1'b1, 6'h00, 6'h00, 3'b000, S_HALT | B_IERR));
`else
        v.push_back(mk(1'b0, 6'h3F, 6'h00, 3'b000, S_ID | B_PCWE));
`endif
        foreach (v[i]) begin
            apply(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                $display("FAIL illegal cyc%0d got %b want %b", i, obs(), v[i].exp);
                failures++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== RET_AFTER_ILL) begin
            $display("FAIL illegal_retired got %0d want %0d", retired, RET_AFTER_ILL);
            failures++;
        end
    endtask

    task automatic test_syscall();
        vec_t v[$];
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));   // illegal_err cleared here
        v.push_back(mk(1'b0, 6'h00, 6'h0C, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b111, S_HALT)); // handshakes ignored
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_HALT));
        foreach (v[i]) begin
            apply(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                $display("FAIL syscall cyc%0d got %b want %b", i, obs(), v[i].exp);
                failures++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== RET_AFTER_ILL) begin
            $display("FAIL syscall_retired got %0d want %0d", retired, RET_AFTER_ILL);
            failures++;
        end
    endtask

    task automatic test_timeout();
        vec_t v[$];
        v.push_back(mk(1'b1, 6'h00, 6'h00, 3'b000, S_HALT));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h08, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b1, 6'h00, 6'h00, 3'b000, S_HALT | B_TERR));
        // Restart clears the error; handshakes on the 4th wait cycle win
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_IF));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_IF));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_IF));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h0A, 6'h00, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b100, S_EX));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_WB | B_PCWE));
        foreach (v[i]) begin
            apply(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                $display("FAIL timeout cyc%0d got %b want %b", i, obs(), v[i].exp);
                failures++;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (retired !== RET_AFTER_ILL + 32'd1) begin
            $display("FAIL timeout_retired got %0d want %0d", retired, RET_AFTER_ILL + 32'd1);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        vec_t w[$];
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b001, S_IF));
        v.push_back(mk(1'b0, 6'h00, 6'h20, 3'b000, S_ID));
        v.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_EX));
        foreach (v[i]) begin
            apply(v[i]);
            checks++;
            if (obs() !== v[i].exp) begin
                $display("FAIL reset_mid cyc%0d got %b want %b", i, obs(), v[i].exp);
                failures++;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== E_IDLE) begin
            $display("FAIL reset_mid_outputs got %b want %b", obs(), E_IDLE); failures++;
        end
        checks++;
        if (retired !== 32'd0) begin
            $display("FAIL reset_mid_retired got %0d want 0", retired); failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        w.push_back(mk(1'b1, 6'h00, 6'h00, 3'b100, E_IDLE));
        w.push_back(mk(1'b0, 6'h00, 6'h00, 3'b000, S_IF));
        foreach (w[i]) begin
            apply(w[i]);
            checks++;
            if (obs() !== w[i].exp) begin
                $display("FAIL reset_mid_restart cyc%0d got %b want %b", i, obs(), w[i].exp);
                failures++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_syscall();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
